gray_to_bin_dec: RTL

Registered Gray-to-binary decoder with a valid/ready stream interface and a step-integrity checker. It accepts Gray codes, such as pointer or position codes produced by the team's binary-to-Gray encoder. It returns the binary value two clock edges later and flags any sample whose Gray code differs from the previous sample in more than one bit. A saturating error counter supports link and sensor health monitoring.

---
 rtl/gray_to_bin_dec_if.sv | 24 ++
 rtl/gray_to_bin_dec.sv | 119 +++++++++++
 2 files changed

// File: rtl/gray_to_bin_dec_if.sv
// Valid/ready stream bundle for the Gray-to-binary decoder.
// The upstream side drives the Gray sample and the downstream side drives ready_in.
interface gray_to_bin_dec_if #(
  parameter int WIDTH = 4
);
  logic             valid_in;
  logic [WIDTH-1:0] gray_in;
  logic             ready_out;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] bin_out;
  logic             step_err_out;
  logic [7:0]       err_cnt_out;

  modport master (
    output valid_in, gray_in, ready_in,
    input  ready_out, valid_out, bin_out, step_err_out, err_cnt_out
  );

  modport slave (
    input  valid_in, gray_in, ready_in,
    output ready_out, valid_out, bin_out, step_err_out, err_cnt_out
  );
endinterface

// File: rtl/gray_to_bin_dec.sv
// Two-stage registered Gray-to-binary decoder with a single-bit-step checker
// and a saturating step-error counter. Bit 0 is the most significant bit.
module gray_to_bin_dec #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  gray_to_bin_dec_if.slave bus
);

  typedef enum logic {
    NO_HIST = 1'b0,
    TRACK   = 1'b1
  } chk_state_t;

  chk_state_t       state;
  chk_state_t       state_next;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_gray;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_bin;
  logic             s2_err;
  logic [7:0]       err_cnt;
  logic [WIDTH-1:0] prev_gray;

  logic             adv;
  logic             move;
  logic             ready;
  logic             accept;
  logic             step_err_next;
  logic [WIDTH-1:0] bin_next;
  logic [7:0]       err_cnt_next;

  function automatic logic [WIDTH-1:0] decode(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[0] = g[0];
    for (int i = 1; i < WIDTH; i++) begin
      b[i] = b[i-1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic multi_bit(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += int'(d[i]);
    end
    return n > 1;
  endfunction

  // ready_out is purely combinational from ready_in so a full pipe still streams.
  assign adv    = !s2_valid || bus.ready_in;
  assign move   = s1_valid && adv;
  assign ready  = !s1_valid || adv;
  assign accept = bus.valid_in && ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next    = state;
    step_err_next = 1'b0;
    bin_next      = decode(s1_gray);
    err_cnt_next  = err_cnt;
    case (state)
      NO_HIST: if (move) state_next = TRACK;
      TRACK:   step_err_next = multi_bit(s1_gray ^ prev_gray);
      default: state_next = NO_HIST;
    endcase
    if (move && step_err_next && err_cnt != 8'hFF) begin
      err_cnt_next = err_cnt + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state     <= NO_HIST;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_bin    <= '0;
      s2_err    <= 1'b0;
      err_cnt   <= 8'd0;
      prev_gray <= '0;
    end else begin
      state <= state_next;

      if (accept) begin
        s1_valid <= 1'b1;
      end else if (move) begin
        s1_valid <= 1'b0;
      end

      if (move) begin
        s2_valid  <= 1'b1;
        s2_bin    <= bin_next;
        s2_err    <= step_err_next;
        err_cnt   <= err_cnt_next;
        prev_gray <= s1_gray;
      end else if (bus.ready_in) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // NOTE: the S1 data register needs no reset; it is only observed when s1_valid is set.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      s1_gray <= bus.gray_in;
    end
  end

  assign bus.ready_out    = ready;
  assign bus.valid_out    = s2_valid;
  assign bus.bin_out      = s2_bin;
  assign bus.step_err_out = s2_err;
  assign bus.err_cnt_out  = err_cnt;

endmodule
